// File: rtl/modport_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package modport_fifo_pkg;

    // Default geometry used when the integrator does not override it.
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;

    // Width of a pointer that addresses 'depth' entries; never below 1 bit.
    function automatic int ptr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage : modport_fifo_pkg

// File: rtl/modport_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// The read register holds its value whenever no read is requested, and is
// the only state here that is cleared by reset; the array itself is not.
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = ptr_width(DEPTH_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write; a same-edge read of the same address sees the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, cleared by reset, holding when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : modport_fifo_mem

// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered read data and four
// occupancy flags decoded from a registered entry count.
//
// Handshake: wr_en and rd_en are requests sampled on each rising edge.
// A write is accepted when the FIFO is not full, or when it is full and a
// read is requested on the same edge (the read frees the slot). A read is
// accepted only when the FIFO holds data; its word appears on dout after
// that edge and stays there until the next accepted read. Rejected
// requests have no effect and are not reported.
//
// DEPTH must be a power of two and at least 4 so that the pointers wrap
// naturally at DEPTH.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int DEPTH            = DEPTH_DEF,
    parameter int ALMOST_FULL_LVL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] AE_LVL    = CW'(ALMOST_EMPTY_LVL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

    // Flags are a pure decode of the registered count.
    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    // A read on the same edge makes room for a write into a full FIFO.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    // Next-state for pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    modport_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (rd_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

endmodule : modport_fifo

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo with a queue-based scoreboard.
module tb_modport_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         full, empty, almost_full, almost_empty;

  modport_fifo #(
    .DATA_WIDTH (W),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // scoreboard: contents the FIFO should hold, oldest first
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout = '0;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".full"},  {31'd0, full},  {31'd0, sz == DEPTH});
    chk({tag, ".empty"}, {31'd0, empty}, {31'd0, sz == 0});
    chk({tag, ".af"},    {31'd0, almost_full},  {31'd0, sz >= DEPTH - 2});
    chk({tag, ".ae"},    {31'd0, almost_empty}, {31'd0, sz <= 2});
  endtask

  // driver: one clock of requests, then model update and checks #1 after the edge
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit wok, rok;
    int sz;
    sz  = exp_q.size();
    wok = w && (sz < DEPTH || r);
    rok = r && (sz > 0);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (rok) exp_dout = exp_q.pop_front();
    if (wok) exp_q.push_back(d);
    chk({tag, ".dout"}, {24'd0, dout}, {24'd0, exp_dout});
    chk_flags(tag);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      cycle(1'b0, 1'b1, '0, tag);
      guard++;
    end
  endtask

  initial begin
    logic w, r;

    // reset state
    #12;
    chk({24'd0, dout} == 32'd0 ? "rst.dout" : "rst.dout", {24'd0, dout}, 32'd0);
    chk_flags("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, W'(i), "fill");
      if (i == 1)  chk("fill.ae_after_2nd", {31'd0, almost_empty}, 32'd1);
      if (i == 2)  chk("fill.ae_after_3rd", {31'd0, almost_empty}, 32'd0);
      if (i == 12) chk("fill.af_after_13th", {31'd0, almost_full}, 32'd0);
      if (i == 13) chk("fill.af_after_14th", {31'd0, almost_full}, 32'd1);
    end
    chk("fill.full", {31'd0, full}, 32'd1);
    cycle(1'b1, 1'b0, 8'hAA, "fill.drop");

    // drain: 0x00..0x0F, one cycle after each rd_en
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, "drain");
      chk("drain.seq", {24'd0, dout}, i);
    end
    chk("drain.empty", {31'd0, empty}, 32'd1);
    cycle(1'b0, 1'b1, '0, "drain.extra");
    chk("drain.hold", {24'd0, dout}, 32'h0F);

    // simultaneous read/write at empty: no fall-through
    cycle(1'b1, 1'b1, 8'h33, "empty_rw");
    chk("empty_rw.dout_held", {24'd0, dout}, 32'h0F);
    chk("empty_rw.not_empty", {31'd0, empty}, 32'd0);
    cycle(1'b0, 1'b1, '0, "empty_rw.read");
    chk("empty_rw.got33", {24'd0, dout}, 32'h33);

    // simultaneous read/write at full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 255)), "refill");
    cycle(1'b1, 1'b1, 8'h55, "full_rw");
    chk("full_rw.still_full", {31'd0, full}, 32'd1);
    drain("full_rw.drain");
    chk("full_rw.last55", {24'd0, dout}, 32'h55);

    // interleaved random traffic across several pointer wraps
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 255)), "wrap.pre");
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (exp_q.size() >= 15 && w && !r) w = 1'b0;
      if (exp_q.size() <= 1 && r && !w) r = 1'b0;
      cycle(w, r, W'($urandom_range(0, 255)), "wrap");
    end
    drain("wrap.drain");

    // flag thresholds at counts 2, 3, 13, 14
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, W'(8'h80 + i), "thr");
      if (i == 1)  begin chk("thr2.ae", {31'd0, almost_empty}, 32'd1); chk("thr2.af", {31'd0, almost_full}, 32'd0); end
      if (i == 2)  begin chk("thr3.ae", {31'd0, almost_empty}, 32'd0); chk("thr3.af", {31'd0, almost_full}, 32'd0); end
      if (i == 12) begin chk("thr13.ae", {31'd0, almost_empty}, 32'd0); chk("thr13.af", {31'd0, almost_full}, 32'd0); end
      if (i == 13) begin chk("thr14.ae", {31'd0, almost_empty}, 32'd0); chk("thr14.af", {31'd0, almost_full}, 32'd1); end
    end
    cycle(1'b0, 1'b1, '0, "thr.read");

    // asynchronous reset in the middle of traffic
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hC3;
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_dout = '0;
    chk("midrst.dout", {24'd0, dout}, 32'd0);
    chk_flags("midrst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 8'h5A, "post_rst.wr");
    cycle(1'b0, 1'b1, '0, "post_rst.rd");
    chk("post_rst.got5A", {24'd0, dout}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_modport_fifo
